ir_receiver: RTL and testbench

IR_RECEIVER -- requirements
Module: ir_receiver

---
 rtl/ir_uart_pkg.sv | 8 +
 rtl/ir_pulse_qual.sv | 25 ++
 rtl/ir_receiver.sv | 75 +++++++
 tb/tb_ir_receiver.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ir_uart_pkg.sv
// ir_uart_pkg: state encoding and timing defaults shared by the IrDA UART receive and transmit paths
package ir_uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} ir_state_t;
  localparam int BIT_CYCLES_DEF = 5208;
  localparam int MIN_PULSE_DEF  = 16;
  localparam int START_LOAD_DEF = 2625;
  localparam int CNT_W          = 13;
endpackage

// File: rtl/ir_pulse_qual.sv
// ir_pulse_qual: synchronizes ir_in and strobes pulse_q once per high run of at least MIN_PULSE clocks
module ir_pulse_qual
  import ir_uart_pkg::*;
#(
  parameter int MIN_PULSE = MIN_PULSE_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic ir_in,
  output logic pulse_q
);
  localparam int W = $clog2(MIN_PULSE + 1);
  logic [1:0]   sync;
  logic [W-1:0] cnt;
  always_ff @(posedge clock)
    if (reset) begin
      sync    <= '0;
      cnt     <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync    <= {sync[0], ir_in};
      cnt     <= !sync[1] ? '0 : cnt == W'(MIN_PULSE) ? cnt : cnt + W'(1);
      pulse_q <= sync[1] && cnt == W'(MIN_PULSE - 1);
    end
endmodule

// File: rtl/ir_receiver.sv
// ir_receiver: IrDA SIR byte receiver; a qualified pulse inside a bit window means 0, no pulse means 1
module ir_receiver
  import ir_uart_pkg::*;
#(
  parameter int BIT_CYCLES = BIT_CYCLES_DEF,
  parameter int MIN_PULSE  = MIN_PULSE_DEF,
  parameter int START_LOAD = START_LOAD_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       ir_in,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_error,
  output logic       busy
);
  ir_state_t        state, state_n;
  logic             pulse_q, pulse_seen, window_end, stop_end;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  ir_pulse_qual #(.MIN_PULSE(MIN_PULSE)) u_qual (
    .clock   (clock),
    .reset   (reset),
    .ir_in   (ir_in),
    .pulse_q (pulse_q)
  );

  assign window_end = bit_cnt == CNT_W'(BIT_CYCLES - 1);
  assign stop_end   = enable && state == STOP && window_end;

  always_ff @(posedge clock)
    state <= reset ? IDLE : state_n;

  always_comb
    state_n = !enable           ? IDLE :
              state == IDLE     ? (pulse_q ? START : IDLE) :
              !window_end       ? state :
              state == START    ? DATA :
              state == DATA     ? (bit_idx == 3'd7 ? STOP : DATA) : IDLE;

  always_comb
    busy = state != IDLE;

  // The start pulse is consumed in IDLE, so pulse_seen only ever collects pulses of later windows
  always_ff @(posedge clock)
    if (reset || !enable) begin
      bit_cnt    <= '0;
      bit_idx    <= '0;
      pulse_seen <= 1'b0;
    end else if (state == IDLE) begin
      if (pulse_q) bit_cnt <= CNT_W'(START_LOAD);
      bit_idx    <= '0;
      pulse_seen <= 1'b0;
    end else begin
      bit_cnt    <= window_end ? '0 : bit_cnt + CNT_W'(1);
      pulse_seen <= !window_end && (pulse_seen || pulse_q);
      if (window_end && state == DATA) bit_idx <= bit_idx + 3'd1;
    end

  always_ff @(posedge clock)
    if (reset) begin
      shift       <= '0;
      data        <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (enable && state == DATA && window_end) shift <= {!pulse_seen, shift[7:1]};
      if (stop_end && !pulse_seen) data <= shift;
      data_valid  <= stop_end && !pulse_seen;
      frame_error <= stop_end && pulse_seen;
    end
endmodule

// File: tb/tb_ir_receiver.sv
// tb_ir_receiver: random and directed IrDA frames checked against a window-arithmetic reference model
module tb_ir_receiver;
  localparam int B = 128;
  localparam int M = 16;
  localparam int L = 64;
  localparam int P = 24;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       ir_in = 1'b0;
  logic [7:0] data;
  logic       data_valid, frame_error, busy;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  int r1 = 0, r2 = 0, r3 = 0;
  bit m_active = 0, m_dv = 0, m_fe = 0;
  bit seen [10];
  logic [7:0] m_data = 8'h00;
  int t0 = 0;
  int dv_cnt = 0, fe_cnt = 0, last_dv = 0, prev_dv = 0;
  bit busy_any = 0;

  ir_receiver #(.BIT_CYCLES(B), .MIN_PULSE(M), .START_LOAD(L)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .ir_in       (ir_in),
    .data        (data),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic finish_run;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      if (n_err >= 20) finish_run();
    end
  endtask

  // Reference: a run of exactly M high samples yields a qualified pulse two cycles later;
  // frame windows are fixed offsets from the first busy cycle t0.
  always @(posedge clock) begin : model
    bit pq;
    int rel;
    cyc++;
    pq = (r3 == M);
    r3 = r2;
    r2 = r1;
    r1 = ir_in ? r1 + 1 : 0;
    m_dv = 0;
    m_fe = 0;
    if (reset) begin
      r1 = 0; r2 = 0; r3 = 0;
      m_active = 0;
      m_data = 8'h00;
    end else if (!enable) begin
      m_active = 0;
    end else if (!m_active) begin
      if (pq) begin
        m_active = 1;
        t0 = cyc;
        foreach (seen[i]) seen[i] = 0;
      end
    end else begin
      rel = (cyc - 1 - t0) + L;
      if (pq && rel % B != B - 1) seen[rel / B] = 1;
      if (cyc == t0 + 10 * B - L) begin
        m_active = 0;
        if (seen[9]) m_fe = 1;
        else begin
          m_dv = 1;
          for (int i = 0; i < 8; i++) m_data[i] = !seen[i + 1];
        end
      end
    end
  end

  always @(negedge clock) begin
    chk("outputs{busy,dv,fe,data}", {21'b0, busy, data_valid, frame_error, data},
        {21'b0, m_active, m_dv, m_fe, m_data});
    busy_any = busy_any | busy;
    if (frame_error) fe_cnt++;
    if (data_valid) begin
      dv_cnt++;
      prev_dv = last_dv;
      last_dv = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse(input int w);
    ir_in = 1'b1;
    tick(w);
    ir_in = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit stop_p, input int w_lo = P,
                      input int w_hi = P, input int jmax = 0, input int nslots = 10);
    for (int s = 0; s < nslots; s++) begin
      int w, j;
      bit p;
      w = $urandom_range(w_hi, w_lo);
      j = $urandom_range(jmax, 0);
      p = (s == 0) || (s == 9 && stop_p);
      if (s >= 1 && s <= 8) p = !b[s-1];
      tick(j);
      if (p) pulse(w); else tick(w);
      tick(B - w - j);
    end
  endtask

  initial begin
    int dv0, fe0;
    tick(3);
    chk("reset busy", 32'(busy), 0);
    chk("reset data", 32'(data), 32'h00);
    chk("reset data_valid", 32'(data_valid), 0);
    chk("reset frame_error", 32'(frame_error), 0);
    reset = 1'b0;
    tick(20);

    dv0 = dv_cnt; fe0 = fe_cnt;
    send(8'hA5, 0);
    chk("A5 data", 32'(data), 32'hA5);
    chk("A5 strobes", 32'(dv_cnt - dv0), 1);
    chk("A5 frame_error", 32'(fe_cnt - fe0), 0);

    dv0 = dv_cnt; fe0 = fe_cnt;
    send(8'h00, 1);
    chk("stop-pulse frame_error", 32'(fe_cnt - fe0), 1);
    chk("stop-pulse no data_valid", 32'(dv_cnt - dv0), 0);
    chk("stop-pulse data held", 32'(data), 32'hA5);
    tick(10);

    dv0 = dv_cnt; fe0 = fe_cnt; busy_any = 0;
    pulse(10);
    tick(B);
    chk("glitch busy", 32'(busy_any), 0);
    chk("glitch data_valid", 32'(dv_cnt - dv0), 0);
    chk("glitch frame_error", 32'(fe_cnt - fe0), 0);

    dv0 = dv_cnt; fe0 = fe_cnt;
    send(8'h00, 0, P, P, 0, 5);
    tick(40);
    enable = 1'b0;
    tick(1);
    chk("enable drop busy", 32'(busy), 0);
    tick(5);
    enable = 1'b1;
    tick(B);
    chk("enable drop strobes", 32'(dv_cnt - dv0 + fe_cnt - fe0), 0);
    send(8'hFF, 0);
    chk("FF after abort", 32'(data), 32'hFF);
    chk("FF strobes", 32'(dv_cnt - dv0), 1);

    send(8'h00, 0, P, P, 0, 4);
    tick(10);
    reset = 1'b1;
    tick(1);
    chk("mid reset busy", 32'(busy), 0);
    chk("mid reset data", 32'(data), 32'h00);
    chk("mid reset data_valid", 32'(data_valid), 0);
    chk("mid reset frame_error", 32'(frame_error), 0);
    reset = 1'b0;
    tick(B);
    send(8'h3C, 0);
    chk("3C after reset", 32'(data), 32'h3C);

    dv0 = dv_cnt;
    send(8'h55, 0);
    send(8'h55, 0);
    chk("b2b strobes", 32'(dv_cnt - dv0), 2);
    chk("b2b spacing", 32'(last_dv - prev_dv), 10 * B);
    chk("b2b data", 32'(data), 32'h55);
    tick(50);

    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(9, 0) == 0) begin
        pulse($urandom_range(M - 1, 1));
        tick(5);
      end
      send(8'($urandom), $urandom_range(3, 0) == 0, M - 1, P, 2,
           $urandom_range(9, 0) == 0 ? $urandom_range(9, 1) : 10);
      if ($urandom_range(7, 0) == 0) begin
        enable = 1'b0;
        tick($urandom_range(20, 1));
        enable = 1'b1;
      end
      tick($urandom_range(150, 0));
    end
    tick(2 * B);
    finish_run();
  end
endmodule
